// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the parametrised ring/Johnson counter.
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    // Anchor state: only the LSB set, legal in both ring and Johnson modes.
    function automatic logic [31:0] anchor_of(input int unsigned width);
        logic [31:0] a;
        a = '0;
        if (width > 0) begin
            a[0] = 1'b1;
        end
        return a;
    endfunction

endpackage

// File: rtl/ring_counter_legal_chk.sv
// Combinational legality check of a counter state for ring or Johnson mode.
module ring_counter_legal_chk
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
)
(
    input  logic [WIDTH-1:0] q,
    input  logic             mode,
    output logic             legal
);

    logic [WIDTH-2:0] edges;

    // A set bit marks a boundary between adjacent bits of differing value.
    assign edges = q[WIDTH-2:0] ^ q[WIDTH-1:1];

    always_comb begin
        legal = 1'b0;
        if (mode == MODE_JOHNSON) begin
            legal = ($countones(edges) <= 1);
        end else begin
            legal = ($countones(q) == 1);
        end
    end

endmodule

// File: rtl/ring_counter_param.sv
// WIDTH-bit ring / Johnson shift counter with load, direction, self-correction,
// and registered wrap/err pulses.
module ring_counter_param
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] d_out,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] ANCHOR = WIDTH'(anchor_of(WIDTH));

    logic [WIDTH-1:0] advance;
    logic [WIDTH-1:0] d_next;
    logic             fill;
    logic             legal;
    logic             wrap_next;
    logic             err_next;

    ring_counter_legal_chk #(
        .WIDTH (WIDTH)
    ) u_legal_chk (
        .q     (d_out),
        .mode  (mode),
        .legal (legal)
    );

    // Bit shifted in: the outgoing end bit, inverted in Johnson mode.
    always_comb begin
        fill    = 1'b0;
        advance = d_out;
        if (dir == DIR_LEFT) begin
            fill    = d_out[WIDTH-1] ^ (mode == MODE_JOHNSON);
            advance = {d_out[WIDTH-2:0], fill};
        end else begin
            fill    = d_out[0] ^ (mode == MODE_JOHNSON);
            advance = {fill, d_out[WIDTH-1:1]};
        end
    end

    // One action per clock: load, then correction, then advance, else hold.
    always_comb begin
        d_next    = d_out;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (load) begin
            d_next = load_val;
        end else if (!legal) begin
            d_next   = ANCHOR;
            err_next = 1'b1;
        end else if (en) begin
            d_next    = advance;
            wrap_next = (advance == ANCHOR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out <= ANCHOR;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            d_out <= d_next;
            wrap  <= wrap_next;
            err   <= err_next;
        end
    end

endmodule

// File: tb/tb_ring_counter_param.sv
// Self-checking bench: WIDTH 2, 4 and 8 counters run side by side against a
// behavioural reference model.
module tb_ring_counter_param;

    localparam int NI = 3;
    localparam int unsigned W0 = 2;
    localparam int unsigned W1 = 4;
    localparam int unsigned W2 = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic        dir;
    logic        load;
    logic [31:0] load_val;

    logic [W0-1:0] q0;
    logic [W1-1:0] q1;
    logic [W2-1:0] q2;
    logic          wrap0, wrap1, wrap2;
    logic          err0, err1, err2;

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    logic [31:0] m_q    [NI];
    logic        m_wrap [NI];
    logic        m_err  [NI];

    always #5 clk = ~clk;

    ring_counter_param #(.WIDTH(W0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val[W0-1:0]), .d_out(q0), .wrap(wrap0), .err(err0)
    );
    ring_counter_param #(.WIDTH(W1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val[W1-1:0]), .d_out(q1), .wrap(wrap1), .err(err1)
    );
    ring_counter_param #(.WIDTH(W2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val[W2-1:0]), .d_out(q2), .wrap(wrap2), .err(err2)
    );

    function automatic int unsigned width_of(int k);
        case (k)
            0:       return W0;
            1:       return W1;
            default: return W2;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(int unsigned w);
        if (w >= 32) return '1;
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] act_q(int k);
        case (k)
            0:       return 32'(q0);
            1:       return 32'(q1);
            default: return 32'(q2);
        endcase
    endfunction

    function automatic logic act_wrap(int k);
        case (k)
            0:       return wrap0;
            1:       return wrap1;
            default: return wrap2;
        endcase
    endfunction

    function automatic logic act_err(int k);
        case (k)
            0:       return err0;
            1:       return err1;
            default: return err2;
        endcase
    endfunction

    // Legality by counting: ring needs exactly one set bit, Johnson at most
    // one place where neighbouring bits differ.
    function automatic bit model_legal(int unsigned w, logic md, logic [31:0] q);
        int n;
        n = 0;
        if (md == 1'b0) begin
            for (int i = 0; i < int'(w); i++) if (q[i]) n++;
            return n == 1;
        end
        for (int i = 0; i < int'(w) - 1; i++) if (q[i] != q[i+1]) n++;
        return n <= 1;
    endfunction

    // Shift by arithmetic on an integer value; Johnson inverts the recirculated bit.
    function automatic logic [31:0] model_adv(int unsigned w, logic md, logic dr, logic [31:0] q);
        logic [31:0] outbit;
        if (dr == 1'b0) begin
            outbit = (q >> (w - 1)) & 32'd1;
            if (md) outbit = outbit ^ 32'd1;
            return ((q << 1) & mask_of(w)) | outbit;
        end
        outbit = q & 32'd1;
        if (md) outbit = outbit ^ 32'd1;
        return (q >> 1) | (outbit << (w - 1));
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_q[k] = 32'd1; m_wrap[k] = 1'b0; m_err[k] = 1'b0;
            end else if (load) begin
                m_q[k] = load_val & mask_of(width_of(k));
                m_wrap[k] = 1'b0; m_err[k] = 1'b0;
            end else if (!model_legal(width_of(k), mode, m_q[k])) begin
                m_q[k] = 32'd1; m_wrap[k] = 1'b0; m_err[k] = 1'b1;
            end else if (en) begin
                m_q[k] = model_adv(width_of(k), mode, dir, m_q[k]);
                m_wrap[k] = (m_q[k] == 32'd1); m_err[k] = 1'b0;
            end else begin
                m_wrap[k] = 1'b0; m_err[k] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b1; dir = 1'b0; load = 1'b0; load_val = '0;
        tick();
        tick();
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (act_q(k) !== 32'd1 || act_wrap(k) !== 1'b0 || act_err(k) !== 1'b0) begin
                n_errs++;
                $display("FAIL reset w=%0d: got q=%h wrap=%b err=%b, expected q=1 wrap=0 err=0",
                         width_of(k), act_q(k), act_wrap(k), act_err(k));
            end
        end
        rst = 1'b0; en = 1'b0; mode = 1'b0;
    endtask

    task automatic test_ring_left();
        logic [31:0] exp_q;
        do_reset();
        mode = 1'b0; dir = 1'b0; en = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                exp_q = 32'd1 << (c % int'(width_of(k)));
                n_checks++;
                if (act_q(k) !== exp_q || act_wrap(k) !== (exp_q == 32'd1) || act_err(k) !== 1'b0) begin
                    n_errs++;
                    $display("FAIL ring_left w=%0d cycle=%0d: got q=%h wrap=%b err=%b, expected q=%h wrap=%b err=0",
                             width_of(k), c, act_q(k), act_wrap(k), act_err(k), exp_q, exp_q == 32'd1);
                end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_johnson();
        logic [3:0] jl [8];
        logic [3:0] jr [8];
        jl = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
        jr = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
        for (int d = 0; d < 2; d++) begin
            do_reset();
            mode = 1'b1; dir = 1'(d); en = 1'b1;
            for (int c = 0; c < 8; c++) begin
                tick();
                n_checks++;
                if (q1 !== ((d == 0) ? jl[c] : jr[c]) || wrap1 !== (c == 7) || err1 !== 1'b0) begin
                    n_errs++;
                    $display("FAIL johnson dir=%0d step=%0d: got q=%h wrap=%b err=%b, expected q=%h wrap=%b err=0",
                             d, c, q1, wrap1, err1, (d == 0) ? jl[c] : jr[c], c == 7);
                end
            end
        end
        en = 1'b0; mode = 1'b0; dir = 1'b0;
    endtask

    task automatic test_load_correct();
        do_reset();
        mode = 1'b0; dir = 1'b0; en = 1'b0;
        load = 1'b1; load_val = 32'h6;
        tick();
        load = 1'b0;
        n_checks++;
        if (q1 !== 4'h6 || err1 !== 1'b0 || wrap1 !== 1'b0) begin
            n_errs++;
            $display("FAIL load_illegal: got q=%h err=%b wrap=%b, expected q=6 err=0 wrap=0", q1, err1, wrap1);
        end
        tick();
        n_checks++;
        if (q1 !== 4'h1 || err1 !== 1'b1 || wrap1 !== 1'b0) begin
            n_errs++;
            $display("FAIL correct: got q=%h err=%b wrap=%b, expected q=1 err=1 wrap=0", q1, err1, wrap1);
        end
        load = 1'b1; load_val = 32'h4;
        tick();
        load = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (q1 !== 4'h4 || err1 !== 1'b0) begin
                n_errs++;
                $display("FAIL load_legal c=%0d: got q=%h err=%b, expected q=4 err=0", c, q1, err1);
            end
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if (act_q(k) !== m_q[k] || act_err(k) !== m_err[k] || act_wrap(k) !== m_wrap[k]) begin
                    n_errs++;
                    $display("FAIL load_model w=%0d c=%0d: got q=%h err=%b wrap=%b, expected q=%h err=%b wrap=%b",
                             width_of(k), c, act_q(k), act_err(k), act_wrap(k), m_q[k], m_err[k], m_wrap[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_hold_dir();
        logic [3:0] seq [3];
        seq = '{4'h2, 4'h1, 4'h8};
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (q1 !== 4'h4 || wrap1 !== 1'b0) begin
                n_errs++;
                $display("FAIL hold c=%0d: got q=%h wrap=%b, expected q=4 wrap=0", c, q1, wrap1);
            end
        end
        dir = 1'b1; en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (q1 !== seq[c] || wrap1 !== (c == 1) || err1 !== 1'b0) begin
                n_errs++;
                $display("FAIL dir_right c=%0d: got q=%h wrap=%b err=%b, expected q=%h wrap=%b err=0",
                         c, q1, wrap1, err1, seq[c], c == 1);
            end
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if (act_q(k) !== m_q[k] || act_wrap(k) !== m_wrap[k] || act_err(k) !== m_err[k]) begin
                    n_errs++;
                    $display("FAIL dir_model w=%0d c=%0d: got q=%h wrap=%b err=%b, expected q=%h wrap=%b err=%b",
                             width_of(k), c, act_q(k), act_wrap(k), act_err(k), m_q[k], m_wrap[k], m_err[k]);
                end
            end
        end
        en = 1'b0; dir = 1'b0;
    endtask

    task automatic test_mode_switch();
        mode = 1'b1; en = 1'b0; load = 1'b1; load_val = 32'h7;
        tick();
        load = 1'b0;
        n_checks++;
        if (q1 !== 4'h7) begin
            n_errs++;
            $display("FAIL johnson_load: got q=%h, expected q=7", q1);
        end
        mode = 1'b0; en = 1'b1;
        tick();
        n_checks++;
        if (q1 !== 4'h1 || err1 !== 1'b1 || wrap1 !== 1'b0) begin
            n_errs++;
            $display("FAIL mode_switch: got q=%h err=%b wrap=%b, expected q=1 err=1 wrap=0", q1, err1, wrap1);
        end
        load = 1'b1; load_val = 32'h2;
        tick();
        load = 1'b0; en = 1'b0;
        n_checks++;
        if (q1 !== 4'h2 || err1 !== 1'b0 || wrap1 !== 1'b0) begin
            n_errs++;
            $display("FAIL load_and_en: got q=%h err=%b wrap=%b, expected q=2 err=0 wrap=0", q1, err1, wrap1);
        end
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (act_q(k) !== m_q[k] || act_err(k) !== m_err[k]) begin
                n_errs++;
                $display("FAIL mode_model w=%0d: got q=%h err=%b, expected q=%h err=%b",
                         width_of(k), act_q(k), act_err(k), m_q[k], m_err[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 1'b0; dir = 1'b0; en = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (q1 !== 4'h1 || wrap1 !== 1'b1) begin
            n_errs++;
            $display("FAIL pre_reset_wrap: got q=%h wrap=%b, expected q=1 wrap=1", q1, wrap1);
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (act_q(k) !== 32'd1 || act_wrap(k) !== 1'b0 || act_err(k) !== 1'b0) begin
                n_errs++;
                $display("FAIL async_reset w=%0d: got q=%h wrap=%b err=%b, expected q=1 wrap=0 err=0",
                         width_of(k), act_q(k), act_wrap(k), act_err(k));
            end
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (q1 !== 4'h2 || wrap1 !== 1'b0 || err1 !== 1'b0) begin
            n_errs++;
            $display("FAIL resume: got q=%h wrap=%b err=%b, expected q=2 wrap=0 err=0", q1, wrap1, err1);
        end
        en = 1'b0;
    endtask

    task automatic test_periods();
        int unsigned period;
        for (int md = 0; md < 2; md++) begin
            do_reset();
            mode = 1'(md); dir = 1'b0; en = 1'b1;
            for (int c = 1; c <= 32; c++) begin
                tick();
                for (int k = 0; k < NI; k++) begin
                    period = (md == 1) ? 2 * width_of(k) : width_of(k);
                    n_checks++;
                    if (act_wrap(k) !== ((c % int'(period)) == 0) || act_q(k) !== m_q[k]) begin
                        n_errs++;
                        $display("FAIL period mode=%0d w=%0d c=%0d: got q=%h wrap=%b, expected q=%h wrap=%b",
                                 md, width_of(k), c, act_q(k), act_wrap(k), m_q[k], (c % int'(period)) == 0);
                    end
                end
            end
        end
        en = 1'b0; mode = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int s = 0; s < 400; s++) begin
            load     = ($urandom_range(0, 7) == 0);
            load_val = $urandom;
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            tick();
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if (act_q(k) !== m_q[k] || act_wrap(k) !== m_wrap[k] || act_err(k) !== m_err[k]) begin
                    n_errs++;
                    $display("FAIL random w=%0d step=%0d: got q=%h wrap=%b err=%b, expected q=%h wrap=%b err=%b",
                             width_of(k), s, act_q(k), act_wrap(k), act_err(k), m_q[k], m_wrap[k], m_err[k]);
                end
            end
        end
        load = 1'b0; en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
        test_reset();
        test_ring_left();
        test_johnson();
        test_load_correct();
        test_hold_dir();
        test_mode_switch();
        test_async_reset();
        test_periods();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
